// File: rtl/ser_rx_fifo.sv
// ser_rx_fifo: oversampled serial receiver (majority-vote bit decisions) feeding a show-ahead word FIFO.
// Define SER_RX_BREAK_EN to enable break detection; otherwise brk is tied 0.
module ser_rx_fifo #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 57600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        pixclk,
  input  logic                        rst_n,
  input  logic                        rxd,
  input  logic                        rd,
  output logic [DATA_BITS-1:0]        rdata,
  output logic                        rvalid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun,
  output logic                        brk,
  input  logic                        clr_err
);
  localparam int DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W  = $clog2(DIV + 1);
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef SER_RX_BREAK_EN
  localparam logic [2:0] S_BREAK  = 3'd5;
  localparam int BIT_TIME = DIV * OVERSAMPLE;
  localparam int HI_W     = $clog2(BIT_TIME + 1);
  logic [HI_W-1:0] hi_cnt_reg;
  logic            zero_reg;
`endif

  logic                 sync1_reg, sync2_reg, armed_reg;
  logic [1:0]           settle_reg, samp_reg;
  logic [2:0]           state_reg, bit_reg;
  logic [DIV_W-1:0]     div_reg;
  logic [TICK_W-1:0]    tick_reg;
  logic [DATA_BITS-1:0] shift_reg, word_reg;
  logic                 par_acc_reg, stop_ok_reg, push_reg;
  logic                 tick, vote_tick, vote, last_stop, stop_ok_now, par_ok;
  logic                 brk_now, good_now, fe_set, pe_set;

  assign tick        = (div_reg == DIV_W'(DIV - 1));
  assign vote_tick   = tick && (tick_reg == TICK_W'(OVERSAMPLE / 2 + 1));
  // 2-of-3 majority: two stored samples plus the live third one
  assign vote        = (samp_reg[0] & samp_reg[1]) | (sync2_reg & (samp_reg[0] | samp_reg[1]));
  assign last_stop   = vote_tick && (state_reg == S_STOP) && (bit_reg == 3'(STOP_BITS - 1));
  assign stop_ok_now = stop_ok_reg & vote;
  assign par_ok      = (PARITY == 0) || (par_acc_reg == (PARITY == 1));
`ifdef SER_RX_BREAK_EN
  assign brk_now     = last_stop & zero_reg & ~vote;
`else
  assign brk_now     = 1'b0;
`endif
  assign good_now    = last_stop & ~brk_now & stop_ok_now & par_ok;
  assign fe_set      = last_stop & ~brk_now & ~stop_ok_now;
  assign pe_set      = last_stop & ~brk_now & ~par_ok;

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      settle_reg  <= '0;
      armed_reg   <= 1'b0;
      state_reg   <= S_IDLE;
      div_reg     <= '0;
      tick_reg    <= '0;
      samp_reg    <= 2'b11;
      bit_reg     <= '0;
      shift_reg   <= '0;
      par_acc_reg <= 1'b0;
      stop_ok_reg <= 1'b1;
      push_reg    <= 1'b0;
      word_reg    <= '0;
`ifdef SER_RX_BREAK_EN
      hi_cnt_reg  <= '0;
      zero_reg    <= 1'b1;
`endif
    end else begin
      sync1_reg  <= rxd;
      sync2_reg  <= sync1_reg;
      settle_reg <= {settle_reg[0], 1'b1};
      push_reg   <= good_now;
      if (good_now) word_reg <= shift_reg;
      case (state_reg)
        S_IDLE: begin
          div_reg  <= '0;
          tick_reg <= '0;
          // only arm once a genuine high has been seen, so a line stuck low never starts a frame
          if (sync2_reg) begin
            armed_reg <= settle_reg[1];
          end else if (armed_reg) begin
            armed_reg   <= 1'b0;
            state_reg   <= S_START;
            bit_reg     <= '0;
            par_acc_reg <= 1'b0;
            stop_ok_reg <= 1'b1;
`ifdef SER_RX_BREAK_EN
            zero_reg    <= 1'b1;
`endif
          end
        end
`ifdef SER_RX_BREAK_EN
        S_BREAK: begin
          hi_cnt_reg <= sync2_reg ? hi_cnt_reg + 1'b1 : '0;
          if (sync2_reg && (hi_cnt_reg == HI_W'(BIT_TIME - 1))) state_reg <= S_IDLE;
        end
`endif
        default: begin
          div_reg <= tick ? '0 : div_reg + 1'b1;
          if (tick) tick_reg <= (tick_reg == TICK_W'(OVERSAMPLE - 1)) ? '0 : tick_reg + 1'b1;
          if (tick && (tick_reg == TICK_W'(OVERSAMPLE / 2 - 1))) samp_reg[0] <= sync2_reg;
          if (tick && (tick_reg == TICK_W'(OVERSAMPLE / 2))) samp_reg[1] <= sync2_reg;
          if (vote_tick) begin
`ifdef SER_RX_BREAK_EN
            zero_reg <= zero_reg & ~vote;
`endif
            case (state_reg)
              S_START: state_reg <= vote ? S_IDLE : S_DATA;
              S_DATA: begin
                shift_reg   <= {vote, shift_reg[DATA_BITS-1:1]};
                par_acc_reg <= par_acc_reg ^ vote;
                if (bit_reg == 3'(DATA_BITS - 1)) begin
                  bit_reg   <= '0;
                  state_reg <= (PARITY != 0) ? S_PARITY : S_STOP;
                end else begin
                  bit_reg <= bit_reg + 1'b1;
                end
              end
              S_PARITY: begin
                par_acc_reg <= par_acc_reg ^ vote;
                state_reg   <= S_STOP;
              end
              default: begin
                stop_ok_reg <= stop_ok_now;
                if (last_stop) begin
                  state_reg <= S_IDLE;
`ifdef SER_RX_BREAK_EN
                  hi_cnt_reg <= '0;
                  if (brk_now) state_reg <= S_BREAK;
`endif
                end else begin
                  bit_reg <= bit_reg + 1'b1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  // Word FIFO: full + push + pop overwrites the slot being popped, so both succeed
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 pop, full, wr_en;

  assign pop        = rd & (count_reg != '0);
  assign full       = (count_reg == CNT_W'(FIFO_DEPTH));
  assign wr_en      = push_reg & (~full | pop);
  assign rvalid     = (count_reg != '0);
  assign rdata      = rvalid ? mem[rd_ptr_reg] : '0;
  assign fifo_count = count_reg;

  always_ff @(posedge pixclk) begin
    if (wr_en) mem[wr_ptr_reg] <= word_reg;
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
      frame_err  <= (frame_err & ~clr_err) | fe_set;
      parity_err <= (parity_err & ~clr_err) | pe_set;
      overrun    <= (overrun & ~clr_err) | (push_reg & full & ~pop);
    end
  end

`ifdef SER_RX_BREAK_EN
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) brk <= 1'b0;
    else        brk <= (brk & ~clr_err) | brk_now;
  end
`else
  assign brk = 1'b0;
`endif
endmodule
